ub_port_arbiter: RTL
====================

UB_PORT_ARBITER -- requirements
Module: ub_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the Unified Buffer byte port (mvin, mvout, quantize, load engines).
REQ-002 SHALL have parameter UB_ADDR_WIDTH, default 16: UB byte-address width.
REQ-003 SHALL have parameter MAX_BURST, default 16: beat cap per grant when the burst limit is compiled in.
REQ-004 SHALL have port CLK, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 SHALL have port ASYNC_RST, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port SYNC_RST, input, 1 bit: synchronous clear, sampled only when EN=1.
REQ-007 SHALL have port EN, input, 1 bit: global enable; when EN=0 all state and outputs hold.
REQ-008 SHALL have port req, input, NUM_REQ bits: per-requester access request, held for the whole burst.
REQ-009 SHALL have port wren, input, NUM_REQ bits: per-requester beat type, 1=write, 0=read.
REQ-010 SHALL have port addr, input, NUM_REQ*UB_ADDR_WIDTH bits: per-requester byte address, slice i belongs to requester i.
REQ-011 SHALL have port wrdata, input, NUM_REQ*8 bits: per-requester write byte.
REQ-012 SHALL have port gnt, output, NUM_REQ bits: one-hot or zero grant.
REQ-013 SHALL have port rdvalid, output, NUM_REQ bits: read data valid for requester i.
REQ-014 SHALL have port rddata, output, 8 bits: shared read byte, qualified by rdvalid.
REQ-015 SHALL have ports UB_en (1), UB_wren (1), UB_addr (UB_ADDR_WIDTH), UB_wrdata (8), all outputs and registered: UB command.
REQ-016 SHALL have port UB_rddata, input, 8 bits: UB read byte, valid one cycle after a read command.
REQ-017 SHALL have port busy, output, 1 bit: high whenever any gnt bit is set.

Function
REQ-018 SHALL implement states IDLE (no owner) and OWN (one requester granted).
REQ-019 SHALL, in IDLE with any req set, pick the winner round-robin starting at last_owner+1 mod NUM_REQ, then register gnt and enter OWN on the next edge.
REQ-020 SHALL, in OWN, issue one beat per cycle for owner i while req[i]=1: next edge sets UB_en=1, UB_wren=wren[i], UB_addr=addr slice i, UB_wrdata=wrdata slice i.
REQ-021 SHALL drive UB_en=0 and UB_wren=0 on any edge where no beat is issued; UB_addr and UB_wrdata then hold their values.
REQ-022 SHALL track each read beat's owner in a one-stage tag pipe and assert rdvalid[owner] with rddata=UB_rddata exactly 2 cycles after the beat cycle, i.e. 1 cycle after UB_en.
REQ-023 SHALL, when req[owner] falls in OWN, clear gnt, set last_owner=owner, and re-arbitrate in the same cycle; a pending requester is granted on the next edge with no idle bubble, otherwise the block enters IDLE.
REQ-024 SHALL deliver in-flight read data to its original owner even after that owner's grant is released or reassigned.
REQ-025 SHALL ignore wren, addr and wrdata of non-granted requesters.
REQ-026 SHALL ignore a req from the current owner that rises again in the cycle after release until normal round-robin selects it.

Reset
REQ-027 SHALL, on ASYNC_RST=1 (immediately) or EN=1 with SYNC_RST=1 (next edge), force state=IDLE, gnt=0, rdvalid=0, rddata=0, UB_en=0, UB_wren=0, UB_addr=0, UB_wrdata=0, busy=0, last_owner=NUM_REQ-1, burst counter=0.
REQ-028 SHALL drop in-flight read tags on reset so that no rdvalid follows reset release.
REQ-029 SHALL place requester 0 first in line after reset.

Configuration
REQ-030 SHALL honor macro UB_ARB_BURST_LIMIT_EN: when defined, a beat counter increments per issued beat and, after beat MAX_BURST when any other req is set, gnt is revoked and the next requester granted per REQ-023 even if req[owner]=1; the counter clears on every new grant.
REQ-031 SHALL, without UB_ARB_BURST_LIMIT_EN, contain no beat counter and hold a grant until req[owner] falls.

Verification
REQ-032 Bench SHALL cover: after reset, req=4'b1111 -> gnt sequence 0001, 0010, 0100, 1000 as each owner drops req after 3 beats, no idle cycle between grants.
REQ-033 Bench SHALL cover: owner 1 writes addr 0x0010, data 0xA5, then reads 0x0010 -> UB_wren=1 one cycle after the write beat; rdvalid=4'b0010 and rddata=0xA5 two cycles after the read beat.
REQ-034 Bench SHALL cover: owner 2 issues a read beat and then drops req; requester 3 is granted -> rdvalid=4'b0100 still asserted, and never 4'b1000, for that byte.
REQ-035 Bench SHALL cover: with UB_ARB_BURST_LIMIT_EN and MAX_BURST=16, req[0] held for 40 cycles while req[1]=1 -> gnt[0] revoked after exactly 16 beats, gnt[1] granted; without the macro, gnt[0] is held for all 40 cycles.
REQ-036 Bench SHALL cover: ASYNC_RST pulsed mid-read -> all outputs 0 at once, no rdvalid afterwards; then req=4'b1010 -> gnt=4'b0010 first.
REQ-037 Bench SHALL cover: EN=0 for 5 cycles mid-burst -> gnt, UB_* and the tag pipe frozen; the burst resumes with no beats lost or duplicated.

Source files
------------

// File: rtl/ub_port_arbiter.sv
// ub_port_arbiter: round-robin owner arbitration for the Unified Buffer byte port.
// Define UB_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats under contention.
module ub_port_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int UB_ADDR_WIDTH = 16,
   parameter int MAX_BURST     = 16
) (
   input  logic                             CLK,
   input  logic                             ASYNC_RST,
   input  logic                             SYNC_RST,
   input  logic                             EN,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               wren,
   input  logic [NUM_REQ*UB_ADDR_WIDTH-1:0] addr,
   input  logic [NUM_REQ*8-1:0]             wrdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [NUM_REQ-1:0]               rdvalid,
   output logic [7:0]                       rddata,
   output logic                             UB_en,
   output logic                             UB_wren,
   output logic [UB_ADDR_WIDTH-1:0]         UB_addr,
   output logic [7:0]                       UB_wrdata,
   input  logic [7:0]                       UB_rddata,
   output logic                             busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] OWN  = 1'b1;

   localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

   if (MAX_BURST < 1) begin : g_bad_burst
      $error("MAX_BURST must be at least 1");
   end

   logic [0:0]               state;
   logic [IW-1:0]            owner;
   logic [IW-1:0]            last_owner;
   logic [IW-1:0]            tag_owner;
   logic                     tag_vld;

   logic                     own_req;
   logic                     own_wren;
   logic [UB_ADDR_WIDTH-1:0] own_addr;
   logic [7:0]               own_wdata;

   logic                     beat;
   logic                     burst_cut;
   logic                     release_own;
   logic                     rearb;

   logic [NUM_REQ-1:0]       cand;
   logic [IW-1:0]            rr_base;
   logic [IW-1:0]            idx;
   logic [IW-1:0]            pick_idx;
   logic                     pick_vld;
   logic [NUM_REQ-1:0]       pick_oh;

   always_comb begin
      own_req   = req[owner];
      own_wren  = wren[owner];
      own_addr  = addr[owner*UB_ADDR_WIDTH +: UB_ADDR_WIDTH];
      own_wdata = wrdata[owner*8 +: 8];
   end

   assign beat        = (state == OWN) && own_req;
   assign release_own = (state == OWN) && (!own_req || burst_cut);
   assign rearb       = (state == IDLE) || release_own;

   // The current owner is masked so a release always passes the port on.
   assign cand    = req & ~gnt;
   assign rr_base = (state == OWN) ? owner : last_owner;

   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      idx      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(rr_base) + k) % NUM_REQ);
         if (!pick_vld && cand[idx]) begin
            pick_vld = 1'b1;
            pick_idx = idx;
         end
      end
   end

   assign pick_oh = NUM_REQ'(1) << pick_idx;

`ifdef UB_ARB_BURST_LIMIT_EN
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CAP = CW'(MAX_BURST - 1);

   logic [CW-1:0] beat_cnt;

   // Saturates at CAP: every later beat is past the limit.
   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         beat_cnt <= '0;
      end else if (EN) begin
         if (SYNC_RST || rearb) begin
            beat_cnt <= '0;
         end else if (beat && beat_cnt != CAP) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

   assign burst_cut = beat && (beat_cnt == CAP) && |cand;
`else
   assign burst_cut = 1'b0;
`endif

   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         state      <= IDLE;
         gnt        <= '0;
         owner      <= '0;
         last_owner <= LAST_INIT;
         tag_vld    <= 1'b0;
         tag_owner  <= '0;
         rdvalid    <= '0;
         UB_en      <= 1'b0;
         UB_wren    <= 1'b0;
         UB_addr    <= '0;
         UB_wrdata  <= '0;
      end else if (EN) begin
         if (SYNC_RST) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            last_owner <= LAST_INIT;
            tag_vld    <= 1'b0;
            tag_owner  <= '0;
            rdvalid    <= '0;
            UB_en      <= 1'b0;
            UB_wren    <= 1'b0;
            UB_addr    <= '0;
            UB_wrdata  <= '0;
         end else begin
            UB_en   <= beat;
            UB_wren <= beat && own_wren;
            if (beat) begin
               UB_addr   <= own_addr;
               UB_wrdata <= own_wdata;
            end

            // Read tags follow the beat, not the grant.
            tag_vld <= beat && !own_wren;
            if (beat) begin
               tag_owner <= owner;
            end
            rdvalid <= tag_vld ? (NUM_REQ'(1) << tag_owner) : '0;

            if (release_own) begin
               last_owner <= owner;
            end
            if (rearb) begin
               if (pick_vld) begin
                  state <= OWN;
                  gnt   <= pick_oh;
                  owner <= pick_idx;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
               end
            end
         end
      end
   end

   assign rddata = (|rdvalid) ? UB_rddata : 8'h00;
   assign busy   = |gnt;

endmodule
